// File: rtl/hyperbus_delay_cfg_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hyperbus_delay_cfg_ctrl_if
//  Description : Bundle of the configuration handshake, PHY hold/busy and
//                delay-line control signals of hyperbus_delay_cfg_ctrl.
//                slave  modport : controller side
//                master modport : register file / PHY / delay line side
//  Ports       : cfg_valid_i, cfg_delay_i, cfg_ready_o   - request handshake
//                phy_busy_i, phy_hold_o                  - PHY interlock
//                clk_en_o, delay_o                       - delay line control
//                update_done_o, busy_o                   - status
//  Revision    : 1.0 - initial release
// ============================================================================
interface hyperbus_delay_cfg_ctrl_if #(
   parameter int DELAY_W = 3
);
   logic               cfg_valid_i;
   logic               cfg_ready_o;
   logic [DELAY_W-1:0] cfg_delay_i;
   logic               phy_busy_i;
   logic               phy_hold_o;
   logic               clk_en_o;
   logic [DELAY_W-1:0] delay_o;
   logic               update_done_o;
   logic               busy_o;

   modport slave (
      input  cfg_valid_i,
      input  cfg_delay_i,
      input  phy_busy_i,
      output cfg_ready_o,
      output phy_hold_o,
      output clk_en_o,
      output delay_o,
      output update_done_o,
      output busy_o
   );

   modport master (
      output cfg_valid_i,
      output cfg_delay_i,
      output phy_busy_i,
      input  cfg_ready_o,
      input  phy_hold_o,
      input  clk_en_o,
      input  delay_o,
      input  update_done_o,
      input  busy_o
   );
endinterface
`default_nettype wire

// File: rtl/hyperbus_delay_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hyperbus_delay_cfg_ctrl
//  Description : Sequences a glitch-free runtime change of the HyperBus
//                RWDS/clock delay-line select: accept request, hold off the
//                PHY, wait for it to go idle, gate the delayed clock, settle,
//                switch the select, settle again, ungate and pulse done.
//  Ports       : clk_i  - system clock
//                rst_i  - asynchronous active-high reset
//                bus    - hyperbus_delay_cfg_ctrl_if.slave (handshake, PHY
//                         interlock, delay line control, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module hyperbus_delay_cfg_ctrl #(
   parameter int                 DELAY_W       = 3,
   parameter int                 SETTLE_CYCLES = 4,
   parameter logic [DELAY_W-1:0] RESET_DELAY   = '0
) (
   input  wire logic               clk_i,
   input  wire logic               rst_i,
   hyperbus_delay_cfg_ctrl_if.slave bus
);

   localparam int             c_CNT_W       = 8;
   localparam [c_CNT_W-1:0]   c_SETTLE_LAST = c_CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_WAIT_IDLE   = 3'd1,
      ST_SETTLE_PRE  = 3'd2,
      ST_SETTLE_POST = 3'd3,
      ST_DONE        = 3'd4
   } state_t;

   state_t               state_q,   state_d;
   logic [DELAY_W-1:0]   pending_q, pending_d;
   logic [DELAY_W-1:0]   delay_q,   delay_d;
   logic [c_CNT_W-1:0]   cnt_q,     cnt_d;

   // Output flops, each loaded from a decode of the next state so that every
   // output is a plain register with the same timing as the state itself.
   logic                 ready_q,   ready_d;
   logic                 busy_q,    busy_d;
   logic                 clk_en_q,  clk_en_d;
   logic                 done_q,    done_d;

   logic                 w_accept;

   // ready_q already reflects IDLE/WAIT_IDLE of the current state.
   assign w_accept = bus.cfg_valid_i & ready_q;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      delay_d   = delay_q;
      cnt_d     = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               if (bus.cfg_delay_i != delay_q) begin
                  pending_d = bus.cfg_delay_i;
                  state_d   = ST_WAIT_IDLE;
               end else begin
                  state_d   = ST_DONE;
               end
            end
         end

         ST_WAIT_IDLE: begin
            if (w_accept) begin
               // Latest request wins, including one that lands in the same
               // cycle the PHY goes idle.
               pending_d = bus.cfg_delay_i;
               if (bus.cfg_delay_i == delay_q) begin
                  state_d = ST_DONE;
               end else if (!bus.phy_busy_i) begin
                  state_d = ST_SETTLE_PRE;
                  cnt_d   = c_SETTLE_LAST;
               end
            end else if (!bus.phy_busy_i) begin
               state_d = ST_SETTLE_PRE;
               cnt_d   = c_SETTLE_LAST;
            end
         end

         ST_SETTLE_PRE: begin
            if (cnt_q == '0) begin
               // Clock is gated here, so switching the mux cannot glitch it.
               delay_d = pending_q;
               cnt_d   = c_SETTLE_LAST;
               state_d = ST_SETTLE_POST;
            end else begin
               cnt_d   = cnt_q - c_CNT_W'(1);
            end
         end

         ST_SETTLE_POST: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d   = cnt_q - c_CNT_W'(1);
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      ready_d  = (state_d == ST_IDLE) || (state_d == ST_WAIT_IDLE);
      busy_d   = (state_d != ST_IDLE);
      clk_en_d = !((state_d == ST_SETTLE_PRE) || (state_d == ST_SETTLE_POST));
      done_d   = (state_d == ST_DONE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         pending_q <= RESET_DELAY;
         delay_q   <= RESET_DELAY;
         cnt_q     <= '0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         clk_en_q  <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         delay_q   <= delay_d;
         cnt_q     <= cnt_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         clk_en_q  <= clk_en_d;
         done_q    <= done_d;
      end
   end

   // Hold and busy share the "not IDLE" condition, hence one flop.
   assign bus.cfg_ready_o   = ready_q;
   assign bus.phy_hold_o    = busy_q;
   assign bus.busy_o        = busy_q;
   assign bus.clk_en_o      = clk_en_q;
   assign bus.delay_o       = delay_q;
   assign bus.update_done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_delay_cfg_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hyperbus_delay_cfg_ctrl
//  Description : Directed self-checking bench for hyperbus_delay_cfg_ctrl
//                (DELAY_W=3, SETTLE_CYCLES=4, RESET_DELAY=0).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hyperbus_delay_cfg_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   pulses;
   int   gated;

   hyperbus_delay_cfg_ctrl_if #(.DELAY_W(3)) bus ();

   hyperbus_delay_cfg_ctrl #(
      .DELAY_W      (3),
      .SETTLE_CYCLES(4),
      .RESET_DELAY  (3'd0)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; sample point is 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (bus.update_done_o !== 1'b1 && n < 60) begin
         step();
         n++;
      end
      check(tag, 32'(bus.update_done_o), 32'd1);
   endtask

   task automatic write(input logic [2:0] val);
      bus.cfg_valid_i = 1'b1;
      bus.cfg_delay_i = val;
      step();
      bus.cfg_valid_i = 1'b0;
   endtask

   initial begin
      bus.cfg_valid_i = 1'b0;
      bus.cfg_delay_i = 3'd0;
      bus.phy_busy_i  = 1'b0;

      // ---- reset ----
      step();
      step();
      check("rst_delay",  32'(bus.delay_o),     32'd0);
      check("rst_clk_en", 32'(bus.clk_en_o),    32'd1);
      check("rst_hold",   32'(bus.phy_hold_o),  32'd0);
      check("rst_ready",  32'(bus.cfg_ready_o), 32'd1);
      check("rst_busy",   32'(bus.busy_o),      32'd0);
      check("rst_done",   32'(bus.update_done_o), 32'd0);
      rst = 1'b0;
      step();

      // ---- basic update to 5, PHY idle ----
      write(3'd5);
      for (int c = 1; c <= 11; c++) begin
         check($sformatf("basic_hold_c%0d", c),   32'(bus.phy_hold_o),    32'(c <= 10));
         check($sformatf("basic_clken_c%0d", c),  32'(bus.clk_en_o),      32'(!(c >= 2 && c <= 9)));
         check($sformatf("basic_delay_c%0d", c),  32'(bus.delay_o),       (c >= 6) ? 32'd5 : 32'd0);
         check($sformatf("basic_done_c%0d", c),   32'(bus.update_done_o), 32'(c == 10));
         check($sformatf("basic_ready_c%0d", c),  32'(bus.cfg_ready_o),   32'(c == 1 || c == 11));
         check($sformatf("basic_busy_c%0d", c),   32'(bus.busy_o),        32'(c <= 10));
         if (c < 11) step();
      end

      // ---- busy PHY delays the gating ----
      bus.phy_busy_i = 1'b1;
      write(3'd3);
      for (int c = 1; c <= 20; c++) begin
         check($sformatf("busy_clken_c%0d", c), 32'(bus.clk_en_o), 32'd1);
         check($sformatf("busy_delay_c%0d", c), 32'(bus.delay_o),  32'd5);
         check($sformatf("busy_hold_c%0d", c),  32'(bus.phy_hold_o), 32'd1);
         step();
      end
      bus.phy_busy_i = 1'b0;
      check("busy_still_clken", 32'(bus.clk_en_o), 32'd1);
      step();
      check("busy_gate_start", 32'(bus.clk_en_o), 32'd0);
      wait_done("busy_done");
      check("busy_delay_final", 32'(bus.delay_o), 32'd3);
      step();
      check("busy_ready_after", 32'(bus.cfg_ready_o), 32'd1);

      // ---- overwrite in WAIT_IDLE ----
      bus.phy_busy_i = 1'b1;
      write(3'd2);
      check("ovr_ready_wait", 32'(bus.cfg_ready_o), 32'd1);
      write(3'd6);
      step();
      step();
      bus.phy_busy_i = 1'b0;
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (bus.update_done_o === 1'b1) pulses++;
      end
      check("ovr_pulses", 32'(pulses), 32'd1);
      check("ovr_delay",  32'(bus.delay_o), 32'd6);

      // ---- overwrite in the same cycle busy drops ----
      bus.phy_busy_i = 1'b1;
      write(3'd2);
      bus.phy_busy_i = 1'b0;
      write(3'd5);
      check("sim_gate", 32'(bus.clk_en_o), 32'd0);
      wait_done("sim_done");
      check("sim_delay", 32'(bus.delay_o), 32'd5);
      step();

      // ---- same value: immediate done ----
      write(3'd5);
      check("same_done_c1",  32'(bus.update_done_o), 32'd1);
      check("same_clken_c1", 32'(bus.clk_en_o),      32'd1);
      check("same_ready_c1", 32'(bus.cfg_ready_o),   32'd0);
      step();
      check("same_done_c2",  32'(bus.update_done_o), 32'd0);
      check("same_ready_c2", 32'(bus.cfg_ready_o),   32'd1);
      check("same_delay",    32'(bus.delay_o),       32'd5);

      // ---- overwrite with the current value from WAIT_IDLE ----
      bus.phy_busy_i = 1'b1;
      gated = 0;
      write(3'd3);
      check("wsame_hold", 32'(bus.phy_hold_o), 32'd1);
      if (bus.clk_en_o !== 1'b1) gated++;
      write(3'd5);
      if (bus.clk_en_o !== 1'b1) gated++;
      check("wsame_done",  32'(bus.update_done_o), 32'd1);
      bus.phy_busy_i = 1'b0;
      step();
      if (bus.clk_en_o !== 1'b1) gated++;
      check("wsame_nogate", 32'(gated), 32'd0);
      check("wsame_ready",  32'(bus.cfg_ready_o), 32'd1);
      check("wsame_delay",  32'(bus.delay_o),     32'd5);

      // ---- reset during SETTLE_POST ----
      write(3'd7);
      repeat (6) step();
      check("mid_delay7",  32'(bus.delay_o),  32'd7);
      check("mid_gated",   32'(bus.clk_en_o), 32'd0);
      #3;
      rst = 1'b1;
      #1;
      check("mid_rst_delay", 32'(bus.delay_o),     32'd0);
      check("mid_rst_clken", 32'(bus.clk_en_o),    32'd1);
      check("mid_rst_hold",  32'(bus.phy_hold_o),  32'd0);
      check("mid_rst_ready", 32'(bus.cfg_ready_o), 32'd1);
      check("mid_rst_busy",  32'(bus.busy_o),      32'd0);
      step();
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (bus.update_done_o === 1'b1) pulses++;
      end
      check("mid_no_done", 32'(pulses), 32'd0);
      write(3'd4);
      wait_done("post_rst_done");
      check("post_rst_delay", 32'(bus.delay_o), 32'd4);
      step();
      check("post_rst_ready", 32'(bus.cfg_ready_o), 32'd1);
      check("post_rst_clken", 32'(bus.clk_en_o),    32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hyperbus_delay_cfg_ctrl.md
Name: hyperbus_delay_cfg_ctrl

Overview:
- Sequences safe runtime updates of the 3-bit select on the HyperBus RWDS/clock delay line.
- Accepts a new delay value from the register file over a valid/ready handshake and holds off new PHY transactions.
- Waits for the PHY to go idle, gates the delayed clock, lets the mux tree settle, then applies the new select.
- After a second settle window it re-enables the clock and signals completion. Sits between the uDMA register interface and the delay line plus PHY.

Parameters:
- DELAY_W, 3: width of the delay select.
- SETTLE_CYCLES, 4: cycles the clock stays gated before and after the select change. Legal values are 1 to 255.
- RESET_DELAY, 3'd0: delay select value after reset.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous, active-high reset.
- cfg_valid_i  input  1  new delay request.
- cfg_ready_o  output  1  controller can accept a request.
- cfg_delay_i  input  DELAY_W  requested delay select.
- phy_busy_i  input  1  PHY transaction in progress.
- phy_hold_o  output  1  PHY must not start a new transaction.
- clk_en_o  output  1  enable for the delayed clock gate (1 = running).
- delay_o  output  DELAY_W  select driven to the delay line.
- update_done_o  output  1  one-cycle pulse when an update completes.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: state IDLE, delay_o = RESET_DELAY, clk_en_o = 1, phy_hold_o = 0, update_done_o = 0, pending register = RESET_DELAY, counter = 0.
- All outputs are driven directly from flops; no combinational path from inputs to clk_en_o or delay_o.
- Handshake: a request is accepted in a cycle where cfg_valid_i & cfg_ready_o. cfg_ready_o = 1 only in IDLE and WAIT_IDLE.
- State IDLE (hold=0, clk_en=1):
  - On accept with cfg_delay_i != delay_o: capture into pending, go to WAIT_IDLE.
  - On accept with cfg_delay_i == delay_o: go to DONE. No gating occurs.
- State WAIT_IDLE (hold=1, clk_en=1):
  - A new accept overwrites pending (latest wins).
  - If the newly accepted value equals delay_o, go to DONE.
  - Otherwise, when phy_busy_i = 0, go to SETTLE_PRE with counter = SETTLE_CYCLES-1.
  - Simultaneous accept and phy_busy_i = 0: the newly accepted value is the one applied.
- State SETTLE_PRE (hold=1, clk_en=0):
  - Counter decrements each cycle.
  - In the cycle counter == 0: load delay_o <= pending, reload counter = SETTLE_CYCLES-1, go to SETTLE_POST.
- State SETTLE_POST (hold=1, clk_en=0):
  - Counter decrements each cycle.
  - At counter == 0, go to DONE.
- State DONE (hold=1, clk_en=1, update_done_o=1): lasts one cycle, then IDLE.
- phy_busy_i is ignored outside WAIT_IDLE. If the PHY asserts busy during gating despite the hold, the sequence still completes.
- Latency: accept at cycle 0 with the PHY idle gives:
  - hold rises at cycle 1;
  - clk_en low for cycles 2 through 2+2*SETTLE_CYCLES-1;
  - delay_o changes at cycle 2+SETTLE_CYCLES;
  - done at cycle 2+2*SETTLE_CYCLES;
  - ready again at cycle 3+2*SETTLE_CYCLES.
- Reset asserted mid-sequence: all state returns to reset values immediately, with clk_en_o = 1 and delay_o = RESET_DELAY. No done pulse is issued.
- delay_o never changes while clk_en_o = 1.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle -> delay_o=0, clk_en_o=1, phy_hold_o=0, cfg_ready_o=1, busy_o=0 immediately.
- Basic update, SETTLE_CYCLES=4, PHY idle: write 5 at cycle 0 -> hold=1 at cycle 1; clk_en_o=0 for cycles 2-9; delay_o=5 at cycle 6; update_done_o pulse at cycle 10; ready at cycle 11.
- Busy PHY: phy_busy_i=1 for 20 cycles after write 3 -> clk_en_o stays 1 and delay_o stays at its old value. Gating starts one cycle after busy drops.
- Overwrite: write 2, then write 6 while in WAIT_IDLE with the PHY busy, then release busy -> delay_o ends at 6 with exactly one update_done_o pulse. Separately: write 6 in the same cycle busy drops -> 6 applied.
- Same value: with delay_o=5, write 5 -> update_done_o at cycle 1, clk_en_o never 0, ready at cycle 2. Separately: in WAIT_IDLE, overwrite with the current value -> DONE, no gating.
- Reset mid-sequence: assert rst_i during SETTLE_POST after delay_o=7 -> delay_o=0, clk_en_o=1, no done pulse, and a subsequent write 4 completes normally.
